// File: rtl/pl_ctrl_pipe_pkg.sv
// Shared definitions for the ID/EX/MEM/WB control pipeline.
// Forward-select codes, link register number and default widths.
package pl_ctrl_pipe_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_EALU = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MMO  = 2'b11
  } fwd_e;

  localparam logic [RW-1:0] REG_RA = 5'd31;

endpackage

// File: rtl/pl_ctrl_pipe_fwd_mux.sv
// Operand bypass mux for the ID stage.
// Picks the register-file value or a later-stage result by forward code.
module pl_fwd_mux
  import pl_ctrl_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   fwd,
  input  logic [W-1:0] reg_q,
  input  logic [W-1:0] e_alu,
  input  logic [W-1:0] m_alu,
  input  logic [W-1:0] m_mo,
  output logic [W-1:0] q
);

  always_comb begin
    q = reg_q;
    unique case (fwd)
      FWD_REG:  q = reg_q;
      FWD_EALU: q = e_alu;
      FWD_MALU: q = m_alu;
      FWD_MMO:  q = m_mo;
      default:  q = reg_q;
    endcase
  end

endmodule

// File: rtl/pl_ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB pipeline registers with operand bypass.
// Stalls only bubble ID/EX; later stages always advance.
module pl_ctrl_pipe
  import pl_ctrl_pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            d_wreg,
  input  logic            d_m2reg,
  input  logic            d_wmem,
  input  logic [3:0]      d_aluc,
  input  logic            d_aluimm,
  input  logic            d_shift,
  input  logic            d_jal,
  input  logic [RW-1:0]   d_rn,
  input  logic [DW-1:0]   d_qa,
  input  logic [DW-1:0]   d_qb,
  input  logic [DW-1:0]   d_imm,
  input  logic [1:0]      fwda,
  input  logic [1:0]      fwdb,
  input  logic            nostall,
  input  logic [DW-1:0]   e_alu,
  input  logic [DW-1:0]   m_mo,
  output logic [DW-1:0]   d_a,
  output logic [DW-1:0]   d_b,
  output logic            ewreg,
  output logic            em2reg,
  output logic [RW-1:0]   ern,
  output logic            mwreg,
  output logic            mm2reg,
  output logic [RW-1:0]   mrn,
  output logic [3:0]      e_aluc,
  output logic            e_aluimm,
  output logic            e_shift,
  output logic            e_jal,
  output logic [DW-1:0]   e_a,
  output logic [DW-1:0]   e_b,
  output logic [DW-1:0]   e_imm,
  output logic            m_wmem,
  output logic [DW-1:0]   m_alu,
  output logic [DW-1:0]   m_b,
  output logic            w_wreg,
  output logic [RW-1:0]   w_rn,
  output logic [DW-1:0]   w_data,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [3:0]    aluc;
    logic          aluimm;
    logic          shift;
    logic          jal;
    logic [RW-1:0] rn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [RW-1:0] rn;
    logic [DW-1:0] alu;
    logic [DW-1:0] b;
  } ex_mem_t;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic [RW-1:0] rn;
    logic [DW-1:0] alu;
    logic [DW-1:0] mo;
  } mem_wb_t;

  id_ex_t  id_nx;
  id_ex_t  ex;
  ex_mem_t mem;
  mem_wb_t wb;

  pl_fwd_mux #(.W(DW)) u_fwd_a (
    .fwd   (fwda),
    .reg_q (d_qa),
    .e_alu (e_alu),
    .m_alu (m_alu),
    .m_mo  (m_mo),
    .q     (d_a)
  );

  pl_fwd_mux #(.W(DW)) u_fwd_b (
    .fwd   (fwdb),
    .reg_q (d_qb),
    .e_alu (e_alu),
    .m_alu (m_alu),
    .m_mo  (m_mo),
    .q     (d_b)
  );

  // A stall turns the ID instruction into a bubble regardless of its enables.
  always_comb begin
    id_nx        = '0;
    id_nx.aluc   = d_aluc;
    id_nx.aluimm = d_aluimm;
    id_nx.shift  = d_shift;
    id_nx.a      = d_a;
    id_nx.b      = d_b;
    id_nx.imm    = d_imm;
    if (nostall) begin
      id_nx.wreg  = d_wreg;
      id_nx.m2reg = d_m2reg;
      id_nx.wmem  = d_wmem;
      id_nx.jal   = d_jal;
      id_nx.rn    = d_rn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex        <= id_nx;
      mem.wreg  <= ewreg;
      mem.m2reg <= em2reg;
      mem.wmem  <= ex.wmem;
      mem.rn    <= ern;
      mem.alu   <= e_alu;
      mem.b     <= ex.b;
      wb.wreg   <= mem.wreg;
      wb.m2reg  <= mem.m2reg;
      wb.rn     <= mem.rn;
      wb.alu    <= mem.alu;
      wb.mo     <= m_mo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!nostall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ewreg    = ex.wreg;
  assign em2reg   = ex.m2reg;
  assign ern      = ex.jal ? REG_RA : ex.rn;
  assign e_aluc   = ex.aluc;
  assign e_aluimm = ex.aluimm;
  assign e_shift  = ex.shift;
  assign e_jal    = ex.jal;
  assign e_a      = ex.a;
  assign e_b      = ex.b;
  assign e_imm    = ex.imm;

  assign mwreg  = mem.wreg;
  assign mm2reg = mem.m2reg;
  assign mrn    = mem.rn;
  assign m_wmem = mem.wmem;
  assign m_alu  = mem.alu;
  assign m_b    = mem.b;

  // $0 is hardwired; never let a write reach it.
  assign w_wreg = wb.wreg & (wb.rn != '0);
  assign w_rn   = wb.rn;
  assign w_data = wb.m2reg ? wb.mo : wb.alu;

endmodule

// File: tb/tb_pl_ctrl_pipe.sv
// Directed-vector bench for pl_ctrl_pipe.
// Second instance with a 2-bit stall counter covers saturation.
module tb_pl_ctrl_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        d_wreg, d_m2reg, d_wmem;
  logic [3:0]  d_aluc;
  logic        d_aluimm, d_shift, d_jal;
  logic [4:0]  d_rn;
  logic [31:0] d_qa, d_qb, d_imm;
  logic [1:0]  fwda, fwdb;
  logic        nostall, ns2;
  logic [31:0] e_alu, m_mo;

  logic [31:0] d_a, d_b, e_a, e_b, e_imm, m_alu, m_b, w_data;
  logic        ewreg, em2reg, mwreg, mm2reg;
  logic [4:0]  ern, mrn, w_rn;
  logic [3:0]  e_aluc;
  logic        e_aluimm, e_shift, e_jal, m_wmem, w_wreg;
  logic [15:0] stall_cnt;

  logic [31:0] x_d_a, x_d_b, x_e_a, x_e_b, x_e_imm, x_m_alu, x_m_b;
  logic [31:0] x_w_data;
  logic        x_ewreg, x_em2reg, x_mwreg, x_mm2reg;
  logic [4:0]  x_ern, x_mrn, x_w_rn;
  logic [3:0]  x_e_aluc;
  logic        x_e_aluimm, x_e_shift, x_e_jal, x_m_wmem, x_w_wreg;
  logic [1:0]  x_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  pl_ctrl_pipe dut (
    .clock(clock), .reset(reset),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_shift(d_shift),
    .d_jal(d_jal), .d_rn(d_rn), .d_qa(d_qa), .d_qb(d_qb),
    .d_imm(d_imm), .fwda(fwda), .fwdb(fwdb), .nostall(nostall),
    .e_alu(e_alu), .m_mo(m_mo), .d_a(d_a), .d_b(d_b),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .e_aluc(e_aluc), .e_aluimm(e_aluimm), .e_shift(e_shift),
    .e_jal(e_jal), .e_a(e_a), .e_b(e_b), .e_imm(e_imm),
    .m_wmem(m_wmem), .m_alu(m_alu), .m_b(m_b),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .stall_cnt(stall_cnt)
  );

  pl_ctrl_pipe #(.CNTW(2)) dut2 (
    .clock(clock), .reset(reset),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_shift(d_shift),
    .d_jal(d_jal), .d_rn(d_rn), .d_qa(d_qa), .d_qb(d_qb),
    .d_imm(d_imm), .fwda(fwda), .fwdb(fwdb), .nostall(ns2),
    .e_alu(e_alu), .m_mo(m_mo), .d_a(x_d_a), .d_b(x_d_b),
    .ewreg(x_ewreg), .em2reg(x_em2reg), .ern(x_ern),
    .mwreg(x_mwreg), .mm2reg(x_mm2reg), .mrn(x_mrn),
    .e_aluc(x_e_aluc), .e_aluimm(x_e_aluimm), .e_shift(x_e_shift),
    .e_jal(x_e_jal), .e_a(x_e_a), .e_b(x_e_b), .e_imm(x_e_imm),
    .m_wmem(x_m_wmem), .m_alu(x_m_alu), .m_b(x_m_b),
    .w_wreg(x_w_wreg), .w_rn(x_w_rn), .w_data(x_w_data),
    .stall_cnt(x_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluc = 0;
    d_aluimm = 0; d_shift = 0; d_jal = 0; d_rn = 0;
    d_qa = 0; d_qb = 0; d_imm = 0;
    fwda = 2'b00; fwdb = 2'b00; nostall = 1;
  endtask

  initial begin
    reset = 1; ns2 = 1; e_alu = 0; m_mo = 0;
    idle();
    step(); step();
    chk("rst_ewreg", 32'(ewreg), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_cnt2", 32'(x_cnt), 0);

    // fill pipeline, then reset mid-flight
    reset = 0;
    d_wreg = 1; d_rn = 5'd7; d_qa = 32'h11; e_alu = 32'h55;
    step(); step(); step();
    chk("fill_w_wreg", 32'(w_wreg), 1);
    chk("fill_w_rn", 32'(w_rn), 7);
    reset = 1;
    step();
    chk("mid_ewreg", 32'(ewreg), 0);
    chk("mid_mwreg", 32'(mwreg), 0);
    chk("mid_w_wreg", 32'(w_wreg), 0);
    chk("mid_e_a", e_a, 0);
    chk("mid_m_alu", m_alu, 0);
    step();
    reset = 0;
    idle(); e_alu = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_w_wreg", 32'(w_wreg), 0);
    end

    // add $3,$1,$2 ; sub $4,$3,$1
    d_wreg = 1; d_rn = 5'd3; d_qa = 32'h1; d_qb = 32'h2;
    #1 chk("add_d_a", d_a, 32'h1);
    step();
    chk("add_ern", 32'(ern), 3);
    chk("add_ewreg", 32'(ewreg), 1);
    chk("add_e_b", e_b, 32'h2);
    d_rn = 5'd4; d_qa = 32'h0; fwda = 2'b01; e_alu = 32'h10;
    #1 chk("sub_fwd_ealu", d_a, 32'h10);
    step();
    chk("add_mrn", 32'(mrn), 3);
    chk("add_m_alu", m_alu, 32'h10);
    chk("sub_e_a", e_a, 32'h10);
    idle(); e_alu = 32'h20;
    step();
    chk("add_w_rn", 32'(w_rn), 3);
    chk("add_w_data", w_data, 32'h10);
    chk("add_w_wreg", 32'(w_wreg), 1);
    step(); step();

    // lw $5,0($0) ; add $6,$5,$5 with one-cycle stall
    d_wreg = 1; d_m2reg = 1; d_rn = 5'd5; e_alu = 0;
    step();
    chk("lw_em2reg", 32'(em2reg), 1);
    d_m2reg = 0; d_rn = 5'd6; nostall = 0;
    step();
    chk("stall_ewreg", 32'(ewreg), 0);
    chk("stall_ern", 32'(ern), 0);
    chk("stall_cnt1", 32'(stall_cnt), 1);
    chk("lw_mrn", 32'(mrn), 5);
    chk("lw_mm2reg", 32'(mm2reg), 1);
    nostall = 1; fwda = 2'b11; fwdb = 2'b11; m_mo = 32'hDEAD_BEEF;
    #1 chk("ld_fwd_a", d_a, 32'hDEAD_BEEF);
    chk("ld_fwd_b", d_b, 32'hDEAD_BEEF);
    step();
    chk("ld_e_a", e_a, 32'hDEAD_BEEF);
    chk("ld_ern", 32'(ern), 6);
    chk("lw_w_rn", 32'(w_rn), 5);
    chk("lw_w_data", w_data, 32'hDEAD_BEEF);
    chk("stall_cnt_hold", 32'(stall_cnt), 1);
    idle(); m_mo = 0;
    step(); step(); step();

    // jal with d_rn=0
    d_wreg = 1; d_jal = 1; d_rn = 5'd0;
    step();
    chk("jal_ern", 32'(ern), 31);
    chk("jal_e_jal", 32'(e_jal), 1);
    idle(); e_alu = 32'h0000_1008;
    step();
    chk("jal_mrn", 32'(mrn), 31);
    e_alu = 0;
    step();
    chk("jal_w_rn", 32'(w_rn), 31);
    chk("jal_w_wreg", 32'(w_wreg), 1);
    chk("jal_w_data", w_data, 32'h0000_1008);

    // addi $0,$0,5
    d_wreg = 1; d_rn = 5'd0; d_aluimm = 1; d_imm = 32'd5;
    step();
    chk("addi_imm", e_imm, 32'd5);
    chk("addi_aluimm", 32'(e_aluimm), 1);
    chk("addi_ern", 32'(ern), 0);
    idle(); e_alu = 32'd5;
    step(); step();
    chk("addi_w_rn", 32'(w_rn), 0);
    chk("addi_w_wreg0", 32'(w_wreg), 0);

    // 2-bit counter saturation
    chk("cnt2_start", 32'(x_cnt), 0);
    ns2 = 0;
    step(); chk("cnt2_1", 32'(x_cnt), 1);
    step(); chk("cnt2_2", 32'(x_cnt), 2);
    step(); chk("cnt2_3", 32'(x_cnt), 3);
    step(); chk("cnt2_sat4", 32'(x_cnt), 3);
    step(); chk("cnt2_sat5", 32'(x_cnt), 3);
    ns2 = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
